// File: rtl/nec_ir_transmitter.sv
// NEC infrared frame transmitter: serialises an address/command pair (or the repeat code)
// as timed marks/spaces, producing a registered envelope and a carrier-modulated LED drive.
module nec_ir_transmitter #(
  parameter int unsigned UNIT_CYCLES  = 28125,
  parameter int unsigned CARRIER_DIV  = 1316,
  parameter int unsigned CARRIER_HIGH = 439,
  parameter int unsigned GUARD_UNITS  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic       repeat_req,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       ir_envelope,
  output logic       ir_out
);

  localparam int unsigned CW   = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned PW   = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;
  localparam int unsigned MAXU = (GUARD_UNITS > 16) ? GUARD_UNITS : 16;
  localparam int unsigned UW   = $clog2(MAXU + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(CARRIER_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH    = PW'(CARRIER_HIGH);
  localparam logic [UW-1:0] U_ONE      = UW'(1);
  localparam logic [UW-1:0] U_THREE    = UW'(3);
  localparam logic [UW-1:0] U_FOUR     = UW'(4);
  localparam logic [UW-1:0] U_EIGHT    = UW'(8);
  localparam logic [UW-1:0] U_SIXTEEN  = UW'(16);
  localparam logic [UW-1:0] U_GUARD    = UW'(GUARD_UNITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GUARD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [31:0]   data_q, data_d;
  logic          rep_q, rep_d;
  logic          env_q, env_d;
  logic          out_q, out_d;
  logic          done_q, done_d;
  logic [UW-1:0] dur;
  logic          state_end;

  function automatic logic is_mark(input state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

  // Duration of the current state in units; bit spaces encode the payload LSB.
  always_comb begin
    dur = U_ONE;
    case (state_q)
      S_LEAD_MARK:  dur = U_SIXTEEN;
      S_LEAD_SPACE: dur = rep_q ? U_FOUR : U_EIGHT;
      S_BIT_SPACE:  dur = data_q[0] ? U_THREE : U_ONE;
      S_GUARD:      dur = U_GUARD;
      default:      dur = U_ONE;
    endcase
  end

  assign state_end = (state_q != S_IDLE) && (cyc_q == CYC_LAST) && (unit_q == dur - U_ONE);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    unit_d    = unit_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    rep_d     = rep_q;
    if (state_q == S_IDLE) begin
      if (send || repeat_req) begin
        state_d   = S_LEAD_MARK;
        rep_d     = ~send;
        data_d    = {~command, command, ~address, address};
        bit_idx_d = 5'd0;
        cyc_d     = '0;
        unit_d    = '0;
      end
    end else if (state_end) begin
      cyc_d  = '0;
      unit_d = '0;
      case (state_q)
        S_LEAD_MARK:  state_d = S_LEAD_SPACE;
        S_LEAD_SPACE: state_d = rep_q ? S_STOP_MARK : S_BIT_MARK;
        S_BIT_MARK:   state_d = S_BIT_SPACE;
        S_BIT_SPACE: begin
          if (bit_idx_q == 5'd31) begin
            state_d = S_STOP_MARK;
          end else begin
            state_d   = S_BIT_MARK;
            bit_idx_d = bit_idx_q + 5'd1;
            data_d    = {1'b0, data_q[31:1]};
          end
        end
        S_STOP_MARK:  state_d = S_GUARD;
        S_GUARD:      state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end else if (cyc_q == CYC_LAST) begin
      cyc_d  = '0;
      unit_d = unit_q + U_ONE;
    end else begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // Outputs are computed from the next state so they register in step with it;
  // the carrier phase restarts on entry to each mark so every burst begins high.
  always_comb begin
    phase_d = phase_q;
    if (is_mark(state_d) && (state_d != state_q)) begin
      phase_d = '0;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
    env_d  = is_mark(state_d);
    out_d  = env_d && (phase_d < PH_HIGH);
    done_d = (state_q == S_GUARD) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      unit_q    <= '0;
      phase_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      rep_q     <= 1'b0;
      env_q     <= 1'b0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      unit_q    <= unit_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      rep_q     <= rep_d;
      env_q     <= env_d;
      out_q     <= out_d;
      done_q    <= done_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign busy        = ~ready;
  assign done        = done_q;
  assign ir_envelope = env_q;
  assign ir_out      = out_q;

endmodule
